// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch-stage sequencer owning the fetch PC, the imem handshake and F->D register control.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stallD_i,
    input  logic             flushD_i,
    input  logic [31:0]      redirect_pc_i,
    output logic             imem_req_o,
    output logic [31:0]      imem_addr_o,
    input  logic             imem_ack_i,
    input  logic [31:0]      imem_rdata_i,
    output logic [31:0]      instrF_o,
    output logic [31:0]      pcPlus4F_o,
    output logic             fd_en_o,
    output logic             fd_clear_o,
    output logic             fetch_busy_o,
    output logic [CNT_W-1:0] wait_cnt_o
);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, READY} state_t;
    state_t           r_state, w_state_nxt;
    logic [31:0]      r_pc, w_pc_nxt, r_buf, r_addr_q, w_redir;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             w_ld_buf;
    assign w_redir = redirect_pc_i & ~32'h3;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_pc       <= RESET_PC;
            r_buf      <= '0;
            r_addr_q   <= '0;
            r_wait_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_ld_buf) r_buf <= imem_rdata_i;
            if (r_state == FETCH) r_addr_q <= r_pc;
            if (r_state != READY && fd_en_o && r_wait_cnt != '1) r_wait_cnt <= r_wait_cnt + CNT_W'(1);
        end
    end
    // A request stays addressed until acked; a redirect mid-request parks in DRAIN.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_ld_buf    = 1'b0;
        case (r_state)
            IDLE:  w_state_nxt = FETCH;
            FETCH: begin
                if (flushD_i) begin
                    w_pc_nxt    = w_redir;
                    w_state_nxt = imem_ack_i ? FETCH : DRAIN;
                end else if (imem_ack_i) begin
                    w_ld_buf    = 1'b1;
                    w_state_nxt = READY;
                end
            end
            DRAIN: begin
                if (flushD_i) w_pc_nxt = w_redir;
                if (imem_ack_i) w_state_nxt = FETCH;
            end
            READY: begin
                if (flushD_i) begin
                    w_pc_nxt    = w_redir;
                    w_state_nxt = FETCH;
                end else if (!stallD_i) begin
                    w_pc_nxt    = r_pc + 32'd4;
                    w_state_nxt = FETCH;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end
    assign imem_req_o   = (r_state == FETCH) | (r_state == DRAIN);
    assign fetch_busy_o = imem_req_o;
    assign imem_addr_o  = (r_state == FETCH) ? r_pc : (r_state == DRAIN) ? r_addr_q : '0;
    assign instrF_o     = (r_state == READY) ? r_buf : '0;
    assign pcPlus4F_o   = (r_state == READY) ? r_pc + 32'd4 : '0;
    assign fd_en_o      = !reset | !stallD_i | flushD_i;
    assign fd_clear_o   = (r_state != READY) | flushD_i;
    assign wait_cnt_o   = r_wait_cnt;
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: scoreboard bench for fetch_ctrl; expected F->D handoffs are queued and popped on delivery.
module tb_fetch_ctrl;
    logic        clk = 1'b0, reset = 1'b1, stallD_i = 1'b0, flushD_i = 1'b0, imem_ack_i = 1'b1;
    logic [31:0] redirect_pc_i = '0;
    logic        imem_req_o, fd_en_o, fd_clear_o, fetch_busy_o;
    logic [31:0] imem_addr_o, imem_rdata_i, instrF_o, pcPlus4F_o;
    logic [15:0] wait_cnt_o;
    int          checks = 0, errors = 0;
    typedef struct packed {logic [31:0] instr; logic [31:0] pc4;} exp_t;
    exp_t        sb[$];

    fetch_ctrl #(.RESET_PC(32'h100), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .stallD_i(stallD_i), .flushD_i(flushD_i),
        .redirect_pc_i(redirect_pc_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i), .instrF_o(instrF_o),
        .pcPlus4F_o(pcPlus4F_o), .fd_en_o(fd_en_o), .fd_clear_o(fd_clear_o),
        .fetch_busy_o(fetch_busy_o), .wait_cnt_o(wait_cnt_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    assign imem_rdata_i = word(imem_addr_o);

    always @(negedge clk) begin
        if (reset && fd_en_o && !fd_clear_o) begin
            exp_t e;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL handoff_unexpected: got instr=%h pc4=%h, required no handoff", instrF_o, pcPlus4F_o);
            end else begin
                e = sb.pop_front();
                if (instrF_o !== e.instr || pcPlus4F_o !== e.pc4) begin
                    errors++;
                    $display("FAIL handoff: got instr=%h pc4=%h, required instr=%h pc4=%h", instrF_o, pcPlus4F_o, e.instr, e.pc4);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #2 reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({imem_req_o, imem_addr_o, instrF_o, pcPlus4F_o, fd_en_o, fd_clear_o, fetch_busy_o, wait_cnt_o} !==
                {1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 16'h0}) begin
                errors++;
                $display("FAIL reset_outputs: got req=%b addr=%h instr=%h pc4=%h en=%b clr=%b busy=%b cnt=%0d, required 0 0 0 0 1 1 0 0",
                         imem_req_o, imem_addr_o, instrF_o, pcPlus4F_o, fd_en_o, fd_clear_o, fetch_busy_o, wait_cnt_o);
            end
        end
        step;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (imem_req_o !== 1'b0 || fetch_busy_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_release: got req=%b busy=%b, required 0 0", imem_req_o, fetch_busy_o);
        end
    endtask

    task automatic test_startup;
        for (int a = 32'h100; a <= 32'h108; a += 4) sb.push_back({word(32'(a)), 32'(a) + 32'd4});
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (k % 2 == 0) begin
                if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100 + 32'(4 * (k / 2))) begin
                    errors++;
                    $display("FAIL startup_fetch%0d: got req=%b addr=%h, required 1 %h", k, imem_req_o, imem_addr_o, 32'h100 + 32'(4 * (k / 2)));
                end
            end else if (imem_req_o !== 1'b0) begin
                errors++;
                $display("FAIL startup_ready%0d: got req=%b, required 0", k, imem_req_o);
            end
        end
    endtask

    task automatic test_wait;
        logic [15:0] c0;
        step;
        imem_ack_i = 1'b0;
        c0 = wait_cnt_o;
        sb.push_back({word(32'h10C), 32'h110});
        for (int i = 0; i < 4; i++) begin
            if (i == 3) imem_ack_i = 1'b1;
            @(negedge clk);
            checks++;
            if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h10C || fd_clear_o !== 1'b1 || fd_en_o !== 1'b1) begin
                errors++;
                $display("FAIL wait_hold%0d: got req=%b addr=%h clr=%b en=%b, required 1 0000010c 1 1", i, imem_req_o, imem_addr_o, fd_clear_o, fd_en_o);
            end
            step;
        end
        checks++;
        if (wait_cnt_o !== c0 + 16'd4) begin
            errors++;
            $display("FAIL wait_cnt: got %0d, required %0d", wait_cnt_o, c0 + 16'd4);
        end
    endtask

    task automatic test_stall;
        logic [15:0] c0;
        c0 = wait_cnt_o;
        stallD_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (fd_en_o !== 1'b0 || imem_req_o !== 1'b0 || instrF_o !== word(32'h10C) || pcPlus4F_o !== 32'h110 || fd_clear_o !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold%0d: got en=%b req=%b instr=%h pc4=%h clr=%b, required 0 0 %h 00000110 0",
                         i, fd_en_o, imem_req_o, instrF_o, pcPlus4F_o, fd_clear_o, word(32'h10C));
            end
            step;
        end
        stallD_i = 1'b0;
        @(negedge clk);
        checks++;
        if (fd_en_o !== 1'b1 || imem_req_o !== 1'b0 || wait_cnt_o !== c0) begin
            errors++;
            $display("FAIL stall_release: got en=%b req=%b cnt=%0d, required 1 0 %0d", fd_en_o, imem_req_o, wait_cnt_o, c0);
        end
        step;
        imem_ack_i = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_addr_o !== 32'h110) begin
            errors++;
            $display("FAIL stall_advance: got addr=%h, required 00000110", imem_addr_o);
        end
    endtask

    task automatic test_redirect;
        step;
        flushD_i = 1'b1;
        redirect_pc_i = 32'h2003;
        @(negedge clk);
        checks++;
        if (fd_en_o !== 1'b1 || fd_clear_o !== 1'b1 || imem_addr_o !== 32'h110 || imem_req_o !== 1'b1) begin
            errors++;
            $display("FAIL redirect_issue: got en=%b clr=%b addr=%h req=%b, required 1 1 00000110 1", fd_en_o, fd_clear_o, imem_addr_o, imem_req_o);
        end
        step;
        flushD_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) imem_ack_i = 1'b1;
            @(negedge clk);
            checks++;
            if (imem_addr_o !== 32'h110 || imem_req_o !== 1'b1 || fetch_busy_o !== 1'b1 || fd_clear_o !== 1'b1) begin
                errors++;
                $display("FAIL drain_hold%0d: got addr=%h req=%b busy=%b clr=%b, required 00000110 1 1 1", i, imem_addr_o, imem_req_o, fetch_busy_o, fd_clear_o);
            end
            step;
        end
        sb.push_back({word(32'h2000), 32'h2004});
        @(negedge clk);
        checks++;
        if (imem_addr_o !== 32'h2000 || imem_req_o !== 1'b1) begin
            errors++;
            $display("FAIL redirect_target: got addr=%h req=%b, required 00002000 1", imem_addr_o, imem_req_o);
        end
    endtask

    task automatic test_stall_flush_ack;
        step;
        step;
        stallD_i = 1'b1;
        flushD_i = 1'b1;
        imem_ack_i = 1'b1;
        redirect_pc_i = 32'h3000;
        @(negedge clk);
        checks++;
        if (fd_en_o !== 1'b1 || fd_clear_o !== 1'b1 || imem_addr_o !== 32'h2004) begin
            errors++;
            $display("FAIL sfa_ctrl: got en=%b clr=%b addr=%h, required 1 1 00002004", fd_en_o, fd_clear_o, imem_addr_o);
        end
        step;
        stallD_i = 1'b0;
        flushD_i = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_addr_o !== 32'h3000 || imem_req_o !== 1'b1) begin
            errors++;
            $display("FAIL sfa_next: got addr=%h req=%b, required 00003000 1", imem_addr_o, imem_req_o);
        end
    endtask

    task automatic test_wrap;
        step;
        stallD_i = 1'b1;
        flushD_i = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        @(negedge clk);
        checks++;
        if (fd_en_o !== 1'b1 || fd_clear_o !== 1'b1 || instrF_o !== word(32'h3000)) begin
            errors++;
            $display("FAIL ready_flush: got en=%b clr=%b instr=%h, required 1 1 %h", fd_en_o, fd_clear_o, instrF_o, word(32'h3000));
        end
        step;
        stallD_i = 1'b0;
        flushD_i = 1'b0;
        sb.push_back({word(32'hFFFF_FFFC), 32'h0});
        @(negedge clk);
        checks++;
        if (imem_addr_o !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_fetch: got addr=%h, required fffffffc", imem_addr_o);
        end
        step;
        @(negedge clk);
        checks++;
        if (pcPlus4F_o !== 32'h0) begin
            errors++;
            $display("FAIL wrap_pc4: got %h, required 00000000", pcPlus4F_o);
        end
        step;
        sb.push_back({word(32'h0), 32'h4});
        @(negedge clk);
        checks++;
        if (imem_addr_o !== 32'h0 || imem_req_o !== 1'b1) begin
            errors++;
            $display("FAIL wrap_next: got addr=%h req=%b, required 00000000 1", imem_addr_o, imem_req_o);
        end
    endtask

    task automatic test_reset_mid;
        step;
        step;
        imem_ack_i = 1'b0;
        flushD_i = 1'b1;
        redirect_pc_i = 32'h500;
        @(negedge clk);
        checks++;
        if (imem_addr_o !== 32'h4) begin
            errors++;
            $display("FAIL mid_fetch: got addr=%h, required 00000004", imem_addr_o);
        end
        step;
        flushD_i = 1'b0;
        @(negedge clk);
        checks++;
        if (fetch_busy_o !== 1'b1 || imem_addr_o !== 32'h4) begin
            errors++;
            $display("FAIL mid_drain: got busy=%b addr=%h, required 1 00000004", fetch_busy_o, imem_addr_o);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({imem_req_o, imem_addr_o, instrF_o, pcPlus4F_o, fd_en_o, fd_clear_o, fetch_busy_o, wait_cnt_o} !==
            {1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 16'h0}) begin
            errors++;
            $display("FAIL mid_reset: got req=%b addr=%h instr=%h pc4=%h en=%b clr=%b busy=%b cnt=%0d, required 0 0 0 0 1 1 0 0",
                     imem_req_o, imem_addr_o, instrF_o, pcPlus4F_o, fd_en_o, fd_clear_o, fetch_busy_o, wait_cnt_o);
        end
        step;
        step;
        reset = 1'b1;
        imem_ack_i = 1'b1;
        sb.push_back({word(32'h100), 32'h104});
        @(negedge clk);
        checks++;
        if (imem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL restart_idle: got req=%b, required 0", imem_req_o);
        end
        @(negedge clk);
        checks++;
        if (imem_addr_o !== 32'h100 || imem_req_o !== 1'b1) begin
            errors++;
            $display("FAIL restart_fetch: got addr=%h req=%b, required 00000100 1", imem_addr_o, imem_req_o);
        end
        @(negedge clk);
        #1;
    endtask

    initial begin
        test_reset;
        test_startup;
        test_wait;
        test_stall;
        test_redirect;
        test_stall_flush_ack;
        test_wrap;
        test_reset_mid;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
